// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS core: load-use stalls,
// branch/jump flushes and data-memory freezes, with saturating perf counters.
module hazard_ctrl #(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [RA_W-1:0]  ex_rt,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             nop_sel,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int WW = $clog2(MAX_MEM_WAIT + 1);

  typedef enum logic [1:0] {RUN, WAIT, FLUSH} state_t;

  state_t          state;
  logic [FW-1:0]   fcnt;
  logic [WW-1:0]   wcnt;
  logic            lu;
  logic            lu_take;

  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // WAIT behaves like RUN once dmem_busy drops, so only FLUSH needs a decode here.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    nop_sel    = 1'b0;
    pipe_hold  = 1'b0;
    lu_take    = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      nop_sel    = 1'b1;
    end else if (dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (state == FLUSH || br_taken) begin
      ifid_flush = 1'b1;
      nop_sel    = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      nop_sel    = 1'b1;
      lu_take    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      fcnt        <= '0;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (dmem_busy) begin
        if (wcnt != WW'(MAX_MEM_WAIT)) wcnt <= wcnt + WW'(1);
        // Flag on the edge that brings wcnt to MAX_MEM_WAIT.
        if (wcnt >= WW'(MAX_MEM_WAIT - 1)) mem_timeout <= 1'b1;
        if (state != FLUSH) state <= WAIT;
      end else begin
        wcnt <= '0;
        if (br_taken) begin
          if (FLUSH_CYCLES > 1) begin
            state <= FLUSH;
            fcnt  <= FW'(FLUSH_CYCLES - 1);
          end else begin
            state <= RUN;
          end
        end else if (state == FLUSH) begin
          if (fcnt <= FW'(1)) begin
            state <= RUN;
            fcnt  <= '0;
          end else begin
            fcnt  <= fcnt - FW'(1);
          end
        end else begin
          state <= RUN;
        end
      end
      if ((lu_take || dmem_busy) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
